// File: rtl/io_dev_pkg.sv
// Shared address map, CTRL bit layout and status-update helpers for the KEY/SW responder.
// Defining IO_DEV_INTR_EN makes the IE bits writable; otherwise they stay 0.
package io_dev_pkg;

    localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
    localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

    localparam int unsigned READY_BIT   = 0;
    localparam int unsigned OVERRUN_BIT = 2;
    localparam int unsigned IE_BIT      = 4;

    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } ctrl_t;

    // Next status for one device; a data update overrides any same-cycle clear.
    function automatic ctrl_t ctrl_next(
        input ctrl_t q,
        input logic  upd,
        input logic  rd,
        input logic  wr,
        input logic  w_ready,
        input logic  w_overrun,
        input logic  w_ie
    );
        ctrl_t n;
        n = q;
        if (wr && !w_overrun) n.overrun = 1'b0;
        if ((wr && !w_ready) || rd) n.ready = 1'b0;
`ifdef IO_DEV_INTR_EN
        if (wr) n.ie = w_ie;
`else
        n.ie = 1'b0 & w_ie;
`endif
        if (upd) begin
            // A read in the same cycle consumes the old value, so it is not lost.
            if (q.ready && !rd) n.overrun = 1'b1;
            n.ready = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [IE_BIT:0] ctrl_bits(input ctrl_t c);
        logic [IE_BIT:0] b;
        b              = '0;
        b[READY_BIT]   = c.ready;
        b[OVERRUN_BIT] = c.overrun;
        b[IE_BIT]      = c.ie;
        return b;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus a single shared stability counter for a WIDTH-bit input vector.
// changed_o is high in the cycle whose clock edge loads a new value into stable_o.
module io_debounce #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o,
    output logic             changed_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta_q, sync_q, prev_q, stable_q, stable_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        changed_o = 1'b0;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (sync_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d  = sync_q;
            cnt_d     = '0;
            changed_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/io_key_sw_device.sv
// Memory-mapped KEY/SW responder with sticky Ready/Overrun status and read-to-clear data.
// Build option IO_DEV_INTR_EN enables the IE bits and the registered intr output.
module io_key_sw_device
    import io_dev_pkg::*;
#(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned KEY_BITS        = 4,
    parameter int unsigned SW_BITS         = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key_n,
    input  logic [SW_BITS-1:0]  sw,
    input  logic [DBITS-1:0]    addr,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [DBITS-1:0]    wr_data,
    output logic [DBITS-1:0]    rd_data,
    output logic                sel,
    output logic                intr
);

    logic [KEY_BITS-1:0] key_meta_q, key_sync_q, key_s, kdata_q;
    logic [SW_BITS-1:0]  sdata;
    logic                k_upd, s_upd;
    logic                hit_kdata, hit_sdata, hit_kctrl, hit_sctrl;
    ctrl_t               kctrl_q, kctrl_d, sctrl_q, sctrl_d;
    logic                unused_wdata;

    assign key_s = ~key_sync_q;
    assign k_upd = (key_s != kdata_q);

    io_debounce #(
        .WIDTH           (SW_BITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk_i     (clk),
        .reset_i   (reset),
        .raw_i     (sw),
        .stable_o  (sdata),
        .changed_o (s_upd)
    );

    assign hit_kdata = (addr == DBITS'(ADDR_KDATA));
    assign hit_sdata = (addr == DBITS'(ADDR_SDATA));
    assign hit_kctrl = (addr == DBITS'(ADDR_KCTRL));
    assign hit_sctrl = (addr == DBITS'(ADDR_SCTRL));
    assign sel       = hit_kdata | hit_sdata | hit_kctrl | hit_sctrl;

    always_comb begin
        kctrl_d = ctrl_next(kctrl_q, k_upd, rd_en && hit_kdata, wr_en && hit_kctrl,
                            wr_data[READY_BIT], wr_data[OVERRUN_BIT], wr_data[IE_BIT]);
        sctrl_d = ctrl_next(sctrl_q, s_upd, rd_en && hit_sdata, wr_en && hit_sctrl,
                            wr_data[READY_BIT], wr_data[OVERRUN_BIT], wr_data[IE_BIT]);
    end

    // Keys are not debounced: KDATA simply tracks the synchronized value.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            kdata_q    <= '0;
            kctrl_q    <= '0;
            sctrl_q    <= '0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            kdata_q    <= key_s;
            kctrl_q    <= kctrl_d;
            sctrl_q    <= sctrl_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit_kdata)      rd_data = DBITS'(kdata_q);
        else if (hit_sdata) rd_data = DBITS'(sdata);
        else if (hit_kctrl) rd_data = DBITS'(ctrl_bits(kctrl_q));
        else if (hit_sctrl) rd_data = DBITS'(ctrl_bits(sctrl_q));
    end

`ifdef IO_DEV_INTR_EN
    logic intr_q;

    always_ff @(posedge clk) begin
        if (reset) intr_q <= 1'b0;
        else       intr_q <= (kctrl_q.ready & kctrl_q.ie) | (sctrl_q.ready & sctrl_q.ie);
    end

    assign intr = intr_q;
`else
    assign intr = 1'b0;
`endif

    assign unused_wdata = ^{wr_data[DBITS-1:IE_BIT], wr_data[3], wr_data[1]};

endmodule

// File: tb/tb_io_key_sw_device.sv
// Scoreboard bench for io_key_sw_device: a behavioural model predicts every load,
// a negedge monitor compares what the DUT returns.
module tb_io_key_sw_device;
    import io_dev_pkg::*;

    localparam int unsigned DEB = 4;
`ifdef IO_DEV_INTR_EN
    localparam bit HasIntr = 1'b1;
`else
    localparam bit HasIntr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [31:0] addr, wr_data, rd_data;
    logic        rd_en, wr_en, sel, intr;

    always #5 clk = ~clk;

    io_key_sw_device #(
        .DBITS           (32),
        .KEY_BITS        (4),
        .SW_BITS         (10),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .sw      (sw),
        .addr    (addr),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .sel     (sel),
        .intr    (intr)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sel;
        logic        intr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] addrs [5] = '{ADDR_KDATA, ADDR_SDATA, ADDR_KCTRL, ADDR_SCTRL, 32'h100};

    // Model: pin history, stable-duration of the synced switches, and status flags.
    logic [3:0] mk1, mk2, mkdata;
    logic [9:0] ms1, ms2, msprev, msdata;
    int         mstable;
    logic       kr, kov, kie, sr, sov, sie, mintr;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == ADDR_KDATA) return 32'(mkdata);
        if (a == ADDR_SDATA) return 32'(msdata);
        if (a == ADDR_KCTRL) return 32'({kie, 1'b0, kov, 1'b0, kr});
        if (a == ADDR_SCTRL) return 32'({sie, 1'b0, sov, 1'b0, sr});
        return 32'h0;
    endfunction

    task automatic status_step(input logic upd, input logic rd, input logic wr,
                               input logic [31:0] wd, inout logic r, inout logic ov,
                               inout logic ie);
        logic r_old;
        r_old = r;
        if (wr && !wd[2]) ov = 1'b0;
        if (upd && r_old && !rd) ov = 1'b1;
        if (rd || (wr && !wd[0])) r = 1'b0;
        if (upd) r = 1'b1;
        if (HasIntr && wr) ie = wd[4];
    endtask

    task automatic model_edge();
        logic [3:0] key_s;
        logic [9:0] sw_s;
        logic       kupd, supd, nintr;
        if (reset) begin
            mk1 = 4'hF; mk2 = 4'hF; mkdata = '0;
            ms1 = '0; ms2 = '0; msprev = '0; msdata = '0; mstable = 0;
            kr = 0; kov = 0; kie = 0; sr = 0; sov = 0; sie = 0; mintr = 0;
            return;
        end
        key_s = ~mk2;
        kupd  = (key_s != mkdata);
        sw_s  = ms2;
        if (sw_s != msprev) mstable = 0;
        else                mstable = mstable + 1;
        supd  = (sw_s != msdata) && (mstable >= DEB);
        nintr = HasIntr && ((kr && kie) || (sr && sie));
        status_step(kupd, rd_en && addr == ADDR_KDATA, wr_en && addr == ADDR_KCTRL, wr_data,
                    kr, kov, kie);
        status_step(supd, rd_en && addr == ADDR_SDATA, wr_en && addr == ADDR_SCTRL, wr_data,
                    sr, sov, sie);
        mintr  = nintr;
        mkdata = key_s;
        if (supd) msdata = sw_s;
        msprev = sw_s;
        mk2 = mk1; mk1 = key_n;
        ms2 = ms1; ms1 = sw;
    endtask

    task automatic tick();
        exp_t e;
        if (rd_en && !reset) begin
            e.data = model_rd(addr);
            e.sel  = (model_rd(addr) != 0) || (addr inside {ADDR_KDATA, ADDR_SDATA,
                                                            ADDR_KCTRL, ADDR_SCTRL});
            e.intr = mintr;
            exp_q.push_back(e);
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd_en = r; wr_en = w; addr = a; wr_data = d;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_en && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: load at addr=%h with no expectation", addr);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e.data || sel !== e.sel || intr !== e.intr) begin
                    errors++;
                    $display("FAIL load addr=%h: got data=%h sel=%b intr=%b, expected data=%h sel=%b intr=%b",
                             addr, rd_data, sel, intr, e.data, e.sel, e.intr);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; key_n = 4'hF; sw = '0;
        addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        reset = 1'b0;

        // Post-reset register values and an unmapped address.
        foreach (addrs[i]) drive(1'b1, 1'b0, addrs[i], 32'h0);

        // Switch debounce timing, then a fast-toggling switch that must never be accepted.
        sw = 10'h005;
        repeat (9) drive(1'b1, 1'b0, ADDR_SCTRL, 32'h0);
        drive(1'b1, 1'b0, ADDR_SDATA, 32'h0);
        drive(1'b1, 1'b0, ADDR_SCTRL, 32'h0);
        for (int i = 0; i < 10; i++) begin
            sw = sw ^ 10'h3F0;
            repeat (3) drive(1'b1, 1'b0, ADDR_SDATA, 32'h0);
        end
        idle(8);
        drive(1'b1, 1'b0, ADDR_SDATA, 32'h0);
        drive(1'b1, 1'b0, ADDR_SCTRL, 32'h0);

        // Key press, read-to-clear, overrun, write-0-to-clear.
        key_n = 4'hE;
        idle(3);
        drive(1'b1, 1'b0, ADDR_KCTRL, 32'h0);
        drive(1'b1, 1'b0, ADDR_KDATA, 32'h0);
        drive(1'b1, 1'b0, ADDR_KCTRL, 32'h0);
        key_n = 4'hC; idle(4);
        key_n = 4'h8; idle(4);
        drive(1'b1, 1'b0, ADDR_KCTRL, 32'h0);
        drive(1'b0, 1'b1, ADDR_KCTRL, 32'h0);
        drive(1'b1, 1'b0, ADDR_KCTRL, 32'h0);
        key_n = 4'h0; idle(4);
        drive(1'b0, 1'b1, ADDR_KCTRL, 32'h5);
        drive(1'b1, 1'b0, ADDR_KCTRL, 32'h0);

        // Key update landing on the same edge as a KDATA load.
        key_n = 4'h1;
        idle(2);
        drive(1'b1, 1'b0, ADDR_KDATA, 32'h0);
        drive(1'b1, 1'b0, ADDR_KCTRL, 32'h0);
        drive(1'b1, 1'b0, ADDR_KDATA, 32'h0);
        drive(1'b1, 1'b0, ADDR_KCTRL, 32'h0);

        // Interrupt enable on the switch device.
        drive(1'b0, 1'b1, ADDR_SCTRL, 32'h10);
        sw = 10'h2A0;
        repeat (10) drive(1'b1, 1'b0, ADDR_SCTRL, 32'h0);
        drive(1'b1, 1'b0, ADDR_SDATA, 32'h0);
        repeat (3) drive(1'b1, 1'b0, ADDR_SCTRL, 32'h0);

        // Randomized traffic with a reset landing mid-debounce.
        for (int c = 0; c < 600; c++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 99);
            a  = addrs[$urandom_range(0, 4)];
            if ($urandom_range(0, 19) == 0) key_n = 4'($urandom);
            if ($urandom_range(0, 29) == 0 || c == 298) sw = 10'($urandom);
            if (c == 300) begin
                rd_en = 1'b0; wr_en = 1'b0;
                reset = 1'b1;
                tick(); tick();
                reset = 1'b0;
            end
            if (op < 45)      drive(1'b1, 1'b0, a, 32'h0);
            else if (op < 60) drive(1'b0, 1'b1, a, $urandom);
            else              idle(1);
        end
        foreach (addrs[i]) drive(1'b1, 1'b0, addrs[i], 32'h0);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
